// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// controller states, address alignment and default memory latency.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [31:0] WORD_ALIGN          = 32'hFFFF_FFFC;
    localparam int          DEFAULT_MEM_LATENCY = 4;
    localparam int          WAIT_CNT_W          = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts the cycles of one external memory access and flags the last one.
// The count restarts whenever the counter is disabled or completes an access.
module mem_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic clk,
    input  logic rst_b,
    input  logic enable,
    output logic terminal
);

    localparam logic [WAIT_CNT_W-1:0] LAST = WAIT_CNT_W'(MEM_LATENCY - 1);

    logic [WAIT_CNT_W-1:0] count;

    assign terminal = enable & (count == LAST);

    // With a latency of one the terminal flag is set on every enabled cycle,
    // so the count never leaves zero and cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count <= '0;
        end else if (!enable || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_controller.sv
// Services MEM-stage cache misses over the single external memory port:
// optional dirty-victim writeback, line fill, then a settle cycle before replay.
module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic             cache_hit,
    input  logic             cache_dirty,
    input  logic [31:0]      victim_addr,
    input  logic             halt_req,
    output logic             stall,
    output logic [31:0]      mem_addr,
    output logic             mem_write_en,
    output logic             cache_fill_en,
    output logic             cache_write_en,
    output logic             halt_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    state_t      next_state;
    logic [31:0] req_latch;
    logic [31:0] victim_latch;
    logic        wait_run;
    logic        wait_done;
    logic        idle_hit;
    logic        idle_miss;

    assign idle_hit  = (state == IDLE) & req_valid & cache_hit;
    assign idle_miss = (state == IDLE) & req_valid & ~cache_hit;
    assign wait_run  = (state == WRITEBACK) | (state == FILL);

    mem_wait_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_wait_counter (
        .clk     (clk),
        .rst_b   (rst_b),
        .enable  (wait_run),
        .terminal(wait_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Addresses are captured on the miss cycle so the pipeline's frozen
    // request lines are never consulted again until the replay.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            req_latch    <= '0;
            victim_latch <= '0;
        end else if (idle_miss) begin
            req_latch    <= word_align(req_addr);
            victim_latch <= word_align(victim_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle_hit && hit_count != CNT_MAX) begin
                hit_count <= hit_count + 1'b1;
            end
            if (idle_miss && miss_count != CNT_MAX) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state     = state;
        stall          = 1'b0;
        mem_addr       = word_align(req_addr);
        mem_write_en   = 1'b0;
        cache_fill_en  = 1'b0;
        cache_write_en = 1'b0;
        halt_ack       = 1'b0;
        case (state)
            IDLE: begin
                cache_write_en = idle_hit & req_write;
                halt_ack       = halt_req & ~idle_miss;
                if (idle_miss) begin
                    stall      = 1'b1;
                    next_state = cache_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                stall        = 1'b1;
                mem_addr     = victim_latch;
                mem_write_en = 1'b1;
                if (wait_done) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_addr = req_latch;
                if (wait_done) begin
                    cache_fill_en = 1'b1;
                    next_state    = DONE;
                end
            end
            DONE: begin
                stall      = 1'b1;
                mem_addr   = req_latch;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: directed vector table, reset-abort sequence, randomized
// miss/hit traffic against a timing model, and a latency-1 / saturation instance.
module tb_mem_access_controller;

    localparam int L = 4;

    typedef struct {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic        hit;
        logic        dirty;
        logic [31:0] victim;
        logic        halt;
        logic        e_stall;
        logic [31:0] e_addr;
        logic        e_we;
        logic        e_fill;
        logic        e_cwe;
        logic        e_ack;
        int          e_hits;
        int          e_misses;
    } vec_t;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] victim_addr;
    logic        halt_req;

    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_write_en;
    logic        cache_fill_en;
    logic        cache_write_en;
    logic        halt_ack;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        s_stall;
    logic [31:0] s_mem_addr;
    logic        s_mem_write_en;
    logic        s_cache_fill_en;
    logic        s_cache_write_en;
    logic        s_halt_ack;
    logic [3:0]  s_hit_count;
    logic [3:0]  s_miss_count;

    int checks = 0;
    int errors = 0;

    mem_access_controller #(.MEM_LATENCY(L), .CNT_W(16)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .victim_addr(victim_addr), .halt_req(halt_req), .stall(stall),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en), .cache_fill_en(cache_fill_en),
        .cache_write_en(cache_write_en), .halt_ack(halt_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    mem_access_controller #(.MEM_LATENCY(1), .CNT_W(4)) dut_small (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
        .victim_addr(victim_addr), .halt_req(halt_req), .stall(s_stall),
        .mem_addr(s_mem_addr), .mem_write_en(s_mem_write_en), .cache_fill_en(s_cache_fill_en),
        .cache_write_en(s_cache_write_en), .halt_ack(s_halt_ack),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a,
                                input logic h, input logic d, input logic [31:0] vic,
                                input logic hl, input logic es, input logic [31:0] ea,
                                input logic ewe, input logic ef, input logic ecwe,
                                input logic eack, input int eh, input int em);
        vec_t r;
        r.valid = v;  r.write = w;  r.addr = a;  r.hit = h;  r.dirty = d;
        r.victim = vic;  r.halt = hl;  r.e_stall = es;  r.e_addr = ea;
        r.e_we = ewe;  r.e_fill = ef;  r.e_cwe = ecwe;  r.e_ack = eack;
        r.e_hits = eh;  r.e_misses = em;
        return r;
    endfunction

    function automatic int sat(input int x, input int max);
        return (x > max) ? max : x;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        req_valid   = v.valid;
        req_write   = v.write;
        req_addr    = v.addr;
        cache_hit   = v.hit;
        cache_dirty = v.dirty;
        victim_addr = v.victim;
        halt_req    = v.halt;
    endtask

    task automatic check_output(input vec_t v, input string tag);
        check_val({tag, ".stall"},          {31'd0, stall},          {31'd0, v.e_stall});
        check_val({tag, ".mem_addr"},       mem_addr,                v.e_addr);
        check_val({tag, ".mem_write_en"},   {31'd0, mem_write_en},   {31'd0, v.e_we});
        check_val({tag, ".cache_fill_en"},  {31'd0, cache_fill_en},  {31'd0, v.e_fill});
        check_val({tag, ".cache_write_en"}, {31'd0, cache_write_en}, {31'd0, v.e_cwe});
        check_val({tag, ".halt_ack"},       {31'd0, halt_ack},       {31'd0, v.e_ack});
        check_val({tag, ".hit_count"},      {16'd0, hit_count},      v.e_hits);
        check_val({tag, ".miss_count"},     {16'd0, miss_count},     v.e_misses);
    endtask

    task automatic run_cycle(input vec_t v, input string tag);
        @(negedge clk);
        apply_stimulus(v);
        #1;
        check_output(v, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    vec_t tbl[$];
    vec_t v;
    int   mh;
    int   mm;
    int   stall_cycles;

    initial begin
        rst_b = 1'b0;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        // Directed table: store hit, clean load miss with replay, dirty store
        // miss with misaligned addresses and halt requested during the fill.
        tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h106, 1, 0, 32'h0,    0, 0, 32'h104, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 0, 32'h0,   0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 32'h40,  0, 0, 32'h1234, 0, 1, 32'h40,  0, 0, 0, 0, 1, 0));
        for (int k = 1; k <= L; k++)
            tbl.push_back(mk(1, 0, 32'h40, 0, 0, 32'h1234, 0, 1, 32'h40, 0, (k == L), 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 32'h40,  0, 0, 32'h1234, 0, 1, 32'h40,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 32'h40,  1, 0, 32'h1234, 0, 0, 32'h40,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(1, 1, 32'h42,  0, 1, 32'h83,   0, 1, 32'h40,  0, 0, 0, 0, 2, 1));
        for (int k = 1; k <= L; k++)
            tbl.push_back(mk(1, 1, 32'h42, 0, 1, 32'h83, 0, 1, 32'h80, 1, 0, 0, 0, 2, 2));
        for (int k = 1; k <= L; k++)
            tbl.push_back(mk(1, 1, 32'h42, 0, 1, 32'h83, 1, 1, 32'h40, 0, (k == L), 0, 0, 2, 2));
        tbl.push_back(mk(1, 1, 32'h42,  0, 1, 32'h83,   1, 1, 32'h40,  0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1, 1, 32'h42,  1, 1, 32'h83,   1, 0, 32'h40,  0, 0, 1, 1, 2, 2));
        tbl.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,    1, 0, 32'h0,   0, 0, 0, 1, 3, 2));

        for (int i = 0; i < tbl.size(); i++)
            run_cycle(tbl[i], $sformatf("table[%0d]", i));

        // Reset landing mid-writeback aborts the transfer without a fill.
        run_cycle(mk(1, 0, 32'h500, 0, 1, 32'h600, 0, 1, 32'h500, 0, 0, 0, 0, 3, 2), "abort.miss");
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_val("abort.wb_before_reset", {31'd0, mem_write_en}, 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_output(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort.after");
        for (int k = 0; k < L + 2; k++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort.idle");

        // Random traffic against a cycle-accurate timing model of each miss.
        mh = 0;
        mm = 0;
        for (int t = 0; t < 60; t++) begin
            logic        rv, rw, rh, rd, hl;
            logic [31:0] ra, va, ra_al, va_al;
            int          total;
            rv = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            hl = 1'($urandom_range(0, 1));
            ra = $urandom;
            va = $urandom;
            ra_al = {ra[31:2], 2'b00};
            va_al = {va[31:2], 2'b00};
            if (!rv || rh) begin
                run_cycle(mk(rv, rw, ra, rh, rd, va, hl, 0, ra_al, 0, 0, rv & rh & rw, hl,
                             sat(mh, 65535), sat(mm, 65535)), "rnd.access");
                if (rv && rh) mh++;
            end else begin
                total = rd ? 2 * L + 2 : L + 2;
                for (int k = 0; k < total; k++) begin
                    if (k == 0) begin
                        v = mk(1, rw, ra, 0, rd, va, hl, 1, ra_al, 0, 0, 0, 0,
                               sat(mh, 65535), sat(mm, 65535));
                    end else begin
                        v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                               1'($urandom_range(0, 1)), 1,
                               (rd && k <= L) ? va_al : ra_al, rd && k <= L,
                               k == total - 2, 0, 0, sat(mh, 65535), sat(mm, 65535));
                    end
                    run_cycle(v, $sformatf("rnd.miss%0d", k));
                    if (k == 0) mm++;
                end
                run_cycle(mk(1, rw, ra, 1, rd, va, hl, 0, ra_al, 0, 0, rw, hl,
                             sat(mh, 65535), sat(mm, 65535)), "rnd.replay");
                mh++;
            end
        end

        // Latency-1 instance: dirty miss then enough hits to saturate a 4-bit counter.
        do_reset();
        stall_cycles = 0;
        @(negedge clk);
        apply_stimulus(mk(1, 0, 32'h201, 0, 1, 32'h302, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_val("lat1.miss_addr", s_mem_addr, 32'h200);
        for (int k = 0; k < 8 && s_stall; k++) begin
            stall_cycles++;
            if (k == 1) begin
                check_val("lat1.wb_addr", s_mem_addr, 32'h300);
                check_val("lat1.wb_we", {31'd0, s_mem_write_en}, 32'd1);
            end
            if (k == 2) begin
                check_val("lat1.fill_addr", s_mem_addr, 32'h200);
                check_val("lat1.fill_en", {31'd0, s_cache_fill_en}, 32'd1);
            end
            @(negedge clk);
            if (k == 3) cache_hit = 1'b1;
            #1;
        end
        check_val("lat1.stall_cycles", stall_cycles, 32'd4);
        check_val("lat1.miss_count", {28'd0, s_miss_count}, 32'd1);
        mh = 0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) begin
                @(negedge clk);
                #1;
            end
            check_val($sformatf("lat1.hits%0d", j), {28'd0, s_hit_count}, sat(mh, 15));
            mh++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check_val("lat1.hit_saturated", {28'd0, s_hit_count}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequences the single external memory port and the MEM-stage data cache of the 5-stage pipelined MIPS core.
- Detects cache misses and freezes the pipeline while they are serviced.
- Writes back dirty victims, fills the missing line, then releases the pipeline so the stalled load/store replays as a hit.
- Also drains outstanding memory traffic before the core halts, and keeps hit/miss statistics.

Parameters:
MEM_LATENCY, 4, cycles the memory needs with address (and write data) held stable per access; legal range 1..15
CNT_W, 16, width of the saturating hit/miss statistics counters

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_b  input  1  reset, synchronous, active-low
req_valid  input  1  MEM stage holds a load or store needing the cache
req_write  input  1  request is a store (sw/sb)
req_addr  input  32  byte address of the request
cache_hit  input  1  cache lookup result for req_addr (combinational from cache)
cache_dirty  input  1  indexed victim line is valid and dirty
victim_addr  input  32  memory address of the indexed victim line
halt_req  input  1  halt instruction has reached the last stage
stall  output  1  freezes IF..MEM stages and their buffers
mem_addr  output  32  external memory address, word-aligned
mem_write_en  output  1  external memory write enable
cache_fill_en  output  1  load memory data into line; set valid, clear dirty
cache_write_en  output  1  store hit updates cache line and sets dirty
halt_ack  output  1  no memory operation pending; core may assert halted
hit_count  output  CNT_W  saturating count of serviced hits
miss_count  output  CNT_W  saturating count of misses

Behaviour:
- Reset (rst_b low at a clock edge): state IDLE, wait counter 0, latched addresses 0, hit_count/miss_count 0. Registered outputs are 0; combinational outputs decode to 0 in IDLE with req_valid low. A reset mid-WRITEBACK/FILL aborts the transfer: mem_write_en drops and no fill occurs.
- States: IDLE, WRITEBACK, FILL, DONE (encoded in shared package).
- IDLE:
  - req_valid & cache_hit: no stall; cache_write_en = req_write in the same cycle (combinational); hit_count++.
  - req_valid & !cache_hit: stall in the same cycle; latch {req_addr[31:2],2'b00} and {victim_addr[31:2],2'b00}; miss_count++. Next state is WRITEBACK if cache_dirty, else FILL.
- WRITEBACK: mem_addr = latched victim address; mem_write_en = 1 for all MEM_LATENCY cycles; counter 0..MEM_LATENCY-1. At count == MEM_LATENCY-1: go to FILL, counter cleared.
- FILL: mem_addr = latched request address; mem_write_en = 0. At count == MEM_LATENCY-1: cache_fill_en = 1 for that one cycle, then go to DONE.
- DONE: single cycle, stall = 1 so the cache lookup settles; then IDLE. In IDLE the frozen request re-presents and hits. A store then asserts cache_write_en; the replay is not counted as a miss again but does count as a hit.
- stall = (state != IDLE) | (req_valid & !cache_hit & state == IDLE).
- mem_addr in IDLE = {req_addr[31:2],2'b00} (pass-through for direct accesses).
- Stall length: clean miss = MEM_LATENCY+2 cycles; dirty miss = 2*MEM_LATENCY+2 cycles.
- req_* inputs are ignored outside IDLE; only latched addresses drive the port.
- MEM_LATENCY = 1: each of WRITEBACK and FILL lasts exactly one cycle; no counter wrap.
- halt_ack = halt_req & state == IDLE & !(req_valid & !cache_hit). A halt arriving mid-miss is acked in the first IDLE cycle after DONE.
- Counters saturate at all-ones; no wrap.
- cache_fill_en and cache_write_en are never high in the same cycle.

Decomposition:
- Package mem_ctrl_pkg: state typedef (IDLE/WRITEBACK/FILL/DONE), WORD_ALIGN mask constant, default latency constant.
- One sub-module, mem_wait_counter: load/clear and terminal-count flag, parameterized by MEM_LATENCY.

Test Plan:
- Reset mid-WRITEBACK (rst_b low at cycle 2 of dirty miss) -> next cycle IDLE, mem_write_en 0, no cache_fill_en, counters 0.
- Store hit, req_addr 0x0000_0106 -> no stall, cache_write_en 1 same cycle, mem_addr 0x0000_0104, hit_count 1.
- Clean load miss, MEM_LATENCY 4, req_addr 0x40 -> stall high 6 cycles, cache_fill_en pulses on cycle 5, mem_write_en never 1, miss_count 1, then replay hit.
- Dirty miss, victim 0x80, req 0x40 -> mem_addr 0x80 with mem_write_en 1 for 4 cycles, then 0x40 for 4 cycles read, stall 10 cycles.
- halt_req during FILL -> halt_ack 0 until first IDLE cycle after DONE, then 1.
- MEM_LATENCY 1 dirty miss -> stall exactly 4 cycles; also force hit_count to 0xFFFF and confirm it holds at 0xFFFF on a further hit.
